// File: rtl/button_conditioner_if.sv
// Groups the raw push-button inputs and the conditioned outputs.
// Latency: none; this file only declares the bundle.
// No backpressure: every signal is a free-running level or pulse.
interface button_conditioner_if;
  logic startStopButton;
  logic resetButton;
  logic start_stop_level;
  logic reset_level;
  logic start_stop_pulse;
  logic reset_pulse;
  logic long_reset_pulse;

  // Board/stimulus side: drives the raw buttons, observes the results.
  modport master (
    output startStopButton, resetButton,
    input  start_stop_level, reset_level, start_stop_pulse, reset_pulse, long_reset_pulse
  );

  // Conditioner side.
  modport slave (
    input  startStopButton, resetButton,
    output start_stop_level, reset_level, start_stop_pulse, reset_pulse, long_reset_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces two push-buttons; emits press pulses and a long-press pulse on reset.
// Latency: stable level and press pulse appear 2+DEBOUNCE_MS cycles after a clean raw change.
// No backpressure: outputs are registered levels and one-cycle pulses, never held off.
module button_conditioner #(
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input logic            clk,
  input logic            reset,
  button_conditioner_if.slave bus
);

  localparam int              CW        = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_MS - 1);
  localparam logic [15:0]     HOLD_LAST = 16'(LONG_PRESS_MS - 1);

  // Index 0 is start/stop, index 1 is reset.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [1:0]    rise;
  logic [1:0]    fall;
  logic [CW-1:0] cnt   [2];
  logic [CW-1:0] cnt_d [2];

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] hold_q;
  logic [15:0] hold_d;
  logic        long_d;

  logic ss_pulse_q;
  logic rs_pulse_q;
  logic long_pulse_q;

  assign raw = {bus.resetButton, bus.startStopButton};

  // Debounce next state: count while the synchronised input disagrees, accept it on the last count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable[i];
      cnt_d[i]    = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_d[i] = sync2[i];
        end else begin
          cnt_d[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable;
  assign fall = stable & ~stable_d;

  // Two-flop synchronisers, debounce counters and stable levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= stable_d;
      cnt[0] <= cnt_d[0];
      cnt[1] <= cnt_d[1];
    end
  end

  // Long-press next state: a press starts the hold count, a release always returns to idle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise[1]) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (fall[1]) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      HELD: begin
        // Counter is left parked so the long pulse cannot repeat.
        if (fall[1]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Long-press state register and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Registered pulses; start/stop is dropped whenever the reset button is (becoming) held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_pulse_q   <= 1'b0;
      rs_pulse_q   <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      ss_pulse_q   <= rise[0] & ~stable_d[1];
      rs_pulse_q   <= rise[1];
      long_pulse_q <= long_d;
    end
  end

  assign bus.start_stop_level = stable[0];
  assign bus.reset_level      = stable[1];
  assign bus.start_stop_pulse = ss_pulse_q;
  assign bus.reset_pulse      = rs_pulse_q;
  assign bus.long_reset_pulse = long_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: stimulus queues expected output events, a monitor matches them by cycle.
// Latency: expects level/pulse 6 edges after a clean press with DEBOUNCE_MS=4.
// No backpressure: the monitor samples every falling edge.
module tb_button_conditioner;

  localparam int LAT = 6;   // 2 sync edges + DEBOUNCE_MS
  localparam int LNG = 10;  // LONG_PRESS_MS

  localparam int K_SS_RISE = 0;
  localparam int K_SS_FALL = 1;
  localparam int K_RS_RISE = 2;
  localparam int K_RS_FALL = 3;
  localparam int K_SS_P    = 4;
  localparam int K_RS_P    = 5;
  localparam int K_LONG    = 6;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  q[$];

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ss_level"}, bus.start_stop_level, 1'b0);
    chk({tag, "_rs_level"}, bus.reset_level, 1'b0);
    chk({tag, "_ss_pulse"}, bus.start_stop_pulse, 1'b0);
    chk({tag, "_rs_pulse"}, bus.reset_pulse, 1'b0);
    chk({tag, "_long"}, bus.long_reset_pulse, 1'b0);
  endtask

  // Monitor: turn every level edge and pulse into an event and match it against the queue.
  logic prev_ss;
  logic prev_rs;
  logic [6:0] ev;
  ev_t exp_e;
  always @(negedge clk) begin
    if (reset) begin
      prev_ss = 1'b0;
      prev_rs = 1'b0;
    end else begin
      ev[K_SS_RISE] = bus.start_stop_level & ~prev_ss;
      ev[K_SS_FALL] = ~bus.start_stop_level & prev_ss;
      ev[K_RS_RISE] = bus.reset_level & ~prev_rs;
      ev[K_RS_FALL] = ~bus.reset_level & prev_rs;
      ev[K_SS_P]    = bus.start_stop_pulse;
      ev[K_RS_P]    = bus.reset_pulse;
      ev[K_LONG]    = bus.long_reset_pulse;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        exp_e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: kind %0d expected at cycle %0d, absent by cycle %0d",
                 exp_e.kind, exp_e.cyc, cyc);
      end
      for (int k = 0; k < 7; k++) begin
        if (ev[k]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
          end else begin
            exp_e = q.pop_front();
            if (exp_e.cyc != cyc || exp_e.kind != k) begin
              errors++;
              $display("FAIL event_match: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                       k, cyc, exp_e.kind, exp_e.cyc);
            end
          end
        end
      end
      prev_ss = bus.start_stop_level;
      prev_rs = bus.reset_level;
    end
  end

  initial begin
    int t;
    int t2;
    cyc    = 0;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.startStopButton = 1'($urandom_range(0, 1));
    bus.resetButton     = 1'($urandom_range(0, 1));

    // Reset with random buttons.
    idle(3);
    bus.startStopButton = 1'($urandom_range(0, 1));
    bus.resetButton     = 1'($urandom_range(0, 1));
    idle(1);
    #1 chk_all_zero("in_reset");
    @(negedge clk);
    bus.startStopButton = 1'b0;
    bus.resetButton     = 1'b0;
    reset = 1'b0;
    idle(10);
    #1 chk_all_zero("after_reset");
    @(negedge clk);

    // Clean start/stop press held 20 cycles, then release.
    t = cyc;
    bus.startStopButton = 1'b1;
    push(t + LAT, K_SS_RISE);
    push(t + LAT, K_SS_P);
    idle(20);
    t = cyc;
    bus.startStopButton = 1'b0;
    push(t + LAT, K_SS_FALL);
    idle(12);

    // Bounce 1,0,1,0 every 2 cycles, then hold.
    for (int i = 0; i < 2; i++) begin
      bus.startStopButton = 1'b1;
      idle(2);
      bus.startStopButton = 1'b0;
      idle(2);
    end
    t = cyc;
    bus.startStopButton = 1'b1;
    push(t + LAT, K_SS_RISE);
    push(t + LAT, K_SS_P);
    idle(12);
    t = cyc;
    bus.startStopButton = 1'b0;
    push(t + LAT, K_SS_FALL);
    idle(12);

    // Reset button: 3-cycle glitch is ignored.
    bus.resetButton = 1'b1;
    idle(3);
    bus.resetButton = 1'b0;
    idle(10);

    // Reset button held 8 cycles: press pulse, released before the long press.
    t = cyc;
    bus.resetButton = 1'b1;
    push(t + LAT, K_RS_RISE);
    push(t + LAT, K_RS_P);
    idle(8);
    t2 = cyc;
    bus.resetButton = 1'b0;
    push(t2 + LAT, K_RS_FALL);
    idle(12);

    // Reset button held 30 cycles: one long pulse 10 cycles after the press pulse.
    t = cyc;
    bus.resetButton = 1'b1;
    push(t + LAT, K_RS_RISE);
    push(t + LAT, K_RS_P);
    push(t + LAT + LNG, K_LONG);
    idle(30);
    t2 = cyc;
    bus.resetButton = 1'b0;
    push(t2 + LAT, K_RS_FALL);
    idle(12);

    // Both pressed together: reset wins, long press follows, start/stop re-press works after.
    t = cyc;
    bus.startStopButton = 1'b1;
    bus.resetButton     = 1'b1;
    push(t + LAT, K_SS_RISE);
    push(t + LAT, K_RS_RISE);
    push(t + LAT, K_RS_P);
    push(t + LAT + LNG, K_LONG);
    idle(20);
    t2 = cyc;
    bus.resetButton = 1'b0;
    push(t2 + LAT, K_RS_FALL);
    idle(10);
    t = cyc;
    bus.startStopButton = 1'b0;
    push(t + LAT, K_SS_FALL);
    idle(10);
    t = cyc;
    bus.startStopButton = 1'b1;
    push(t + LAT, K_SS_RISE);
    push(t + LAT, K_SS_P);
    idle(10);
    t = cyc;
    bus.startStopButton = 1'b0;
    push(t + LAT, K_SS_FALL);
    idle(10);

    // Start/stop pressed while reset level is high: level follows, pulse is lost.
    t = cyc;
    bus.resetButton = 1'b1;
    push(t + LAT, K_RS_RISE);
    push(t + LAT, K_RS_P);
    idle(8);
    bus.startStopButton = 1'b1;
    push(t + 8 + LAT, K_SS_RISE);
    push(t + LAT + LNG, K_LONG);
    idle(12);
    bus.startStopButton = 1'b0;
    push(t + 20 + LAT, K_SS_FALL);
    idle(2);
    bus.resetButton = 1'b0;
    push(t + 22 + LAT, K_RS_FALL);
    idle(12);

    // Asynchronous reset while the long-press FSM is counting: no long pulse afterwards.
    t = cyc;
    bus.resetButton = 1'b1;
    push(t + LAT, K_RS_RISE);
    push(t + LAT, K_RS_P);
    idle(8);
    chk("pre_async_rs_level", bus.reset_level, 1'b1);
    bus.resetButton = 1'b0;
    reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    idle(20);

    // Every expected event must have been seen.
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d events still pending, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the two raw board push-buttons before they reach the stopwatch run/reset controller.
- Per button: synchronises, debounces, and emits single-cycle press pulses plus a clean level.
- The reset button also gets a long-press detector, used by the top level to clear the loaded timer value.
- Clocked by the 1 kHz divided clock, so one cycle = 1 ms.

Parameters:
- DEBOUNCE_MS, 20: consecutive cycles a synchronised input must differ from the stable level before the stable level changes; legal range 2..255.
- LONG_PRESS_MS, 1000: consecutive cycles the stable reset level must stay high before long_reset_pulse fires; must exceed DEBOUNCE_MS; legal up to 65535.

Ports:
- clk  input  1  1 kHz divided clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- startStopButton  input  1  raw, asynchronous, bouncy start/stop button.
- resetButton  input  1  raw, asynchronous, bouncy reset button.
- start_stop_level  output  1  debounced start/stop button level.
- reset_level  output  1  debounced reset button level.
- start_stop_pulse  output  1  one-cycle pulse on a debounced start/stop press.
- reset_pulse  output  1  one-cycle pulse on a debounced reset press.
- long_reset_pulse  output  1  one-cycle pulse when reset has been held LONG_PRESS_MS cycles.

Behaviour:
- Reset (asynchronous): every register and output goes to 0, including synchronisers, counters, stable levels, pulses and the FSM (to IDLE). Reset applied mid-debounce or mid-hold abandons the operation; no pulse is emitted.
- Synchroniser: two flip-flops per button; only the second-stage value (sync) is used downstream.
- Debounce, per button:
  - Counter width is ceil(log2(DEBOUNCE_MS+1)).
  - While sync == stable, the counter is held at 0.
  - While sync != stable, the counter increments each cycle.
  - At the edge where the counter == DEBOUNCE_MS-1 and sync still differs, stable <= sync and the counter clears.
  - Any single cycle of sync == stable clears the counter; the count restarts from 0.
- Latency: raw input changes and stays constant before edge 0. Sync is valid after edge 2. Stable changes at edge 2+DEBOUNCE_MS. Releases use the same rule.
- Pulses:
  - Pulses are registered and asserted at the same edge the stable level rises 0->1, for exactly one cycle.
  - A stable fall produces no pulse.
- Priority: start_stop_pulse is suppressed (forced 0) in any cycle where reset_level is 1 or reset_pulse is being asserted. A suppressed press is lost, not queued.
- Long-press FSM on the reset button, with a hold counter of 16 bits:
  - IDLE -> PRESSED on the stable reset rise. At this edge the hold counter loads 0 and reset_pulse fires.
  - PRESSED: the hold counter increments each cycle. When it reaches LONG_PRESS_MS-1, go to HELD and assert long_reset_pulse for one cycle.
  - PRESSED -> IDLE on a stable fall. No long pulse is emitted.
  - HELD -> IDLE on a stable fall. The FSM stays in HELD otherwise; the counter saturates and there is no repeat pulse.
  - Unused/illegal state encodings go to IDLE.
- Simultaneous events: if both buttons stabilise high on the same edge, reset_pulse fires and start_stop_pulse is suppressed. The two buttons are otherwise independent.
- No combinational path from any input to any output.

Test Plan:
- Use DEBOUNCE_MS=4, LONG_PRESS_MS=10 for all scenarios.
- Assert reset with random buttons, release -> all outputs 0. Assert reset while the FSM is in PRESSED -> outputs 0 asynchronously, FSM IDLE, no pulse after release.
- Clean startStopButton press held 20 cycles -> start_stop_level rises at edge 6 after the press. start_stop_pulse is high for exactly one cycle at that edge. Release -> level falls 6 edges later, no pulse.
- Bounce: startStopButton toggles 1,0,1,0 with 2-cycle periods, then holds 1 -> no pulse during the bounce. Exactly one pulse, 6 edges after the final rise.
- resetButton held 3 cycles then released -> reset_level stays 0, no pulses. Held 8 cycles -> one reset_pulse, no long_reset_pulse.
- resetButton held 30 cycles -> reset_pulse at stable rise. long_reset_pulse exactly 10 cycles later, once. No further pulses until release and re-press.
- Both buttons pressed on the same cycle -> reset_pulse=1 and start_stop_pulse=0 on that edge. start_stop_pulse stays 0 while reset_level=1. Release reset first, then re-press start/stop -> start_stop_pulse fires normally.
